// File: rtl/b7_alu_pkg.sv
// Shared types and constants for the 7-bit chunked add/subtract datapath.
package b7_alu_pkg;

  localparam int unsigned CHUNK_W = 7;

  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;

  typedef enum logic {OP_ADD, OP_SUB} addsub_op_t;

endpackage

// File: rtl/B7Adder.sv
// 7-bit ripple-carry adder; the single shared arithmetic element of the serial sequencer.
module B7Adder
  import b7_alu_pkg::*;
(
  input  logic [CHUNK_W-1:0] i_a,
  input  logic [CHUNK_W-1:0] i_b,
  input  logic               i_cin,
  output logic [CHUNK_W-1:0] o_sum,
  output logic               o_cout
);

  always_comb begin : p_ripple
    logic w_c;
    o_sum  = '0;
    w_c    = i_cin;
    for (int i = 0; i < CHUNK_W; i++) begin
      o_sum[i] = i_a[i] ^ i_b[i] ^ w_c;
      w_c      = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
    end
    o_cout = w_c;
  end

endmodule

// File: rtl/b7_serial_addsub_ctrl.sv
// Serial WORDS*7-bit add/subtract: streams operands LSB chunk first through one B7Adder,
// holding the inter-chunk carry in a flop and publishing S/Cout/Overflow atomically.
module b7_serial_addsub_ctrl
  import b7_alu_pkg::*;
#(
  parameter int unsigned WORDS = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       Start,
  input  logic                       Op,
  input  logic [WORDS*CHUNK_W-1:0]   A,
  input  logic [WORDS*CHUNK_W-1:0]   B,
  output logic                       Busy,
  output logic                       Done,
  output logic [WORDS*CHUNK_W-1:0]   S,
  output logic                       Cout,
  output logic                       Overflow
);

  localparam int unsigned W     = WORDS * CHUNK_W;
  localparam int unsigned IDX_W = $clog2(WORDS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  seq_state_t         r_state;
  seq_state_t         w_state_next;
  logic [W-1:0]       r_areg;
  logic [W-1:0]       r_breg;
  logic [W-1:0]       r_res;
  logic               r_carry;
  logic [IDX_W-1:0]   r_idx;
  logic               r_a_msb;
  logic               r_b_msb;
  logic [W-1:0]       r_s;
  logic               r_cout;
  logic               r_ovf;

  addsub_op_t         w_op;
  logic [W-1:0]       w_b_eff;
  logic               w_start;
  logic               w_last;
  logic [CHUNK_W-1:0] w_sum;
  logic               w_cout;
  logic [W-1:0]       w_res_next;

  assign w_op       = addsub_op_t'(Op);
  // Subtraction is A + ~B + 1; the +1 enters through the initial carry.
  assign w_b_eff    = (w_op == OP_SUB) ? ~B : B;
  assign w_start    = (r_state == IDLE) && Start;
  assign w_last     = (r_idx == LAST_IDX);
  assign w_res_next = {w_sum, r_res[W-1:CHUNK_W]};

  B7Adder u_adder (
    .i_a    (r_areg[CHUNK_W-1:0]),
    .i_b    (r_breg[CHUNK_W-1:0]),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (Start) w_state_next = RUN;
      RUN:     if (w_last) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_areg  <= '0;
      r_breg  <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_start) begin
      r_areg  <= A;
      r_breg  <= w_b_eff;
      r_carry <= (w_op == OP_SUB);
      r_idx   <= '0;
      r_a_msb <= A[W-1];
      r_b_msb <= w_b_eff[W-1];
    end else if (r_state == RUN) begin
      r_res   <= w_res_next;
      r_carry <= w_cout;
      r_areg  <= r_areg >> CHUNK_W;
      r_breg  <= r_breg >> CHUNK_W;
      r_idx   <= r_idx + 1'b1;
      // Results are published only on the final chunk, so outputs never show partial sums.
      if (w_last) begin
        r_s    <= w_res_next;
        r_cout <= w_cout;
        r_ovf  <= (r_a_msb == r_b_msb) && (w_res_next[W-1] != r_a_msb);
      end
    end
  end

  assign Busy     = (r_state == RUN);
  assign Done     = (r_state == DONE);
  assign S        = r_s;
  assign Cout     = r_cout;
  assign Overflow = r_ovf;

endmodule

// File: tb/tb_b7_serial_addsub_ctrl.sv
// Directed bench for b7_serial_addsub_ctrl with WORDS=4 (28-bit operands).
module tb_b7_serial_addsub_ctrl;

  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = WORDS * 7;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         Start = 1'b0;
  logic         Op = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Busy;
  logic         Done;
  logic [W-1:0] S;
  logic         Cout;
  logic         Overflow;

  int n_cmp = 0;
  int n_err = 0;

  b7_serial_addsub_ctrl #(
    .WORDS (WORDS)
  ) u_dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .Start    (Start),
    .Op       (Op),
    .A        (A),
    .B        (B),
    .Busy     (Busy),
    .Done     (Done),
    .S        (S),
    .Cout     (Cout),
    .Overflow (Overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op and observe 10 cycles. mode 1: disturb inputs while busy; mode 2: reset in RUN idx 2.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                        input int mode, output int busy_n, output int done_k,
                        output int done_n, output int overlap);
    busy_n  = 0;
    done_k  = 0;
    done_n  = 0;
    overlap = 0;
    @(negedge clk);
    A     = a;
    B     = b;
    Op    = op;
    Start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) Start = 1'b0;
      if (Busy) busy_n++;
      if (Done) begin
        done_n++;
        if (done_k == 0) done_k = k;
      end
      if (Busy && Done) overlap++;
      if (mode == 1 && k == 2) begin
        Start = 1'b1;
        A     = 28'hFFF_FFFF;
        B     = 28'hFFF_FFFF;
        Op    = ~op;
      end
      if (mode == 1 && k == 3) Start = 1'b0;
      if (mode == 2 && k == 3) reset_n = 1'b0;
      if (mode == 2 && k == 4) begin
        reset_n = 1'b1;
        check_eq("rst_busy", {31'd0, Busy}, 32'd0);
        check_eq("rst_s", {4'd0, S}, 32'd0);
        check_eq("rst_cout", {31'd0, Cout}, 32'd0);
      end
    end
  endtask

  task automatic do_vec(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic op, input int mode, input logic [W-1:0] exp_s,
                        input logic exp_c, input logic exp_v);
    int busy_n, done_k, done_n, overlap;
    run_op(a, b, op, mode, busy_n, done_k, done_n, overlap);
    check_eq({tag, "_busy_cycles"}, busy_n, WORDS);
    check_eq({tag, "_done_cycle"}, done_k, WORDS + 1);
    check_eq({tag, "_done_count"}, done_n, 1);
    check_eq({tag, "_overlap"}, overlap, 0);
    check_eq({tag, "_s"}, {4'd0, S}, {4'd0, exp_s});
    check_eq({tag, "_cout"}, {31'd0, Cout}, {31'd0, exp_c});
    check_eq({tag, "_ovf"}, {31'd0, Overflow}, {31'd0, exp_v});
  endtask

  initial begin
    int busy_n, done_k, done_n, overlap;
    int dones;

    repeat (3) @(negedge clk);
    check_eq("reset_busy", {31'd0, Busy}, 32'd0);
    check_eq("reset_done", {31'd0, Done}, 32'd0);
    check_eq("reset_s", {4'd0, S}, 32'd0);
    check_eq("reset_cout", {31'd0, Cout}, 32'd0);
    check_eq("reset_ovf", {31'd0, Overflow}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    do_vec("add_chunk",  28'h000_007F, 28'h000_0001, 1'b0, 0, 28'h000_0080, 1'b0, 1'b0);
    do_vec("add_wrap",   28'hFFF_FFFF, 28'h000_0001, 1'b0, 0, 28'h000_0000, 1'b1, 1'b0);
    do_vec("sub_borrow", 28'h000_0005, 28'h000_0007, 1'b1, 0, 28'hFFF_FFFE, 1'b0, 1'b0);
    do_vec("sub_plain",  28'h000_0007, 28'h000_0005, 1'b1, 0, 28'h000_0002, 1'b1, 1'b0);
    do_vec("add_ovf",    28'h7FF_FFFF, 28'h000_0001, 1'b0, 0, 28'h800_0000, 1'b0, 1'b1);
    do_vec("sub_ovf",    28'h800_0000, 28'h000_0001, 1'b1, 0, 28'h7FF_FFFF, 1'b1, 1'b1);
    do_vec("busy_start", 28'h123_4567, 28'h011_1111, 1'b0, 1, 28'h134_5678, 1'b0, 1'b0);

    // Reset mid-operation: no Done, outputs cleared, then a clean op.
    run_op(28'h0AB_CDEF, 28'h000_0001, 1'b1, 2, busy_n, done_k, done_n, overlap);
    check_eq("rst_no_done", done_n, 0);
    check_eq("rst_busy_cycles", busy_n, 3);
    check_eq("rst_s_after", {4'd0, S}, 32'd0);
    do_vec("post_rst",   28'h555_5555, 28'h2AA_AAAB, 1'b0, 0, 28'h800_0000, 1'b0, 1'b1);

    // Start held high: one op per WORDS+2 cycles.
    dones = 0;
    @(negedge clk);
    A     = 28'h000_0001;
    B     = 28'h000_0002;
    Op    = 1'b0;
    Start = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (Done) dones++;
    end
    Start = 1'b0;
    check_eq("b2b_dones", dones, 2);
    repeat (8) @(negedge clk);
    check_eq("b2b_s", {4'd0, S}, 32'd3);
    check_eq("b2b_idle", {31'd0, Busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
